// File: rtl/ball_centroid_if.sv
// ball_centroid_if: pixel-stream inputs and per-frame centroid results of ball_centroid.
// master drives the pixel stream, slave (the centroid block) drives the results.
interface ball_centroid_if #(
  parameter int COORD_W = 13
);
  logic               pix_valid;
  logic [COORD_W-1:0] row;
  logic [COORD_W-1:0] col;
  logic               mask;
  logic               frame_end;
  logic [COORD_W-1:0] ball_row;
  logic [COORD_W-1:0] ball_col;
  logic               ball_found;
  logic               centroid_valid;
  logic               busy;
  logic               overrun;

  modport master (
    output pix_valid, row, col, mask, frame_end,
    input  ball_row, ball_col, ball_found, centroid_valid, busy, overrun
  );

  modport slave (
    input  pix_valid, row, col, mask, frame_end,
    output ball_row, ball_col, ball_found, centroid_valid, busy, overrun
  );
endinterface

// File: rtl/ball_centroid.sv
// ball_centroid: per-frame mask-hit centroid via a sequential restoring divider, result
// 2*SUM_W+2 cycles after frame_end. Macro CENTROID_IIR_EN averages each found result with the last.
module ball_centroid #(
  parameter int COORD_W    = 13,
  parameter int SUM_W      = 32,
  parameter int MIN_PIXELS = 16
) (
  input  logic           clk,
  input  logic           reset_n,
  ball_centroid_if.slave bus
);
  localparam logic [1:0] ACCUM   = 2'd0;
  localparam logic [1:0] DIV_R   = 2'd1;
  localparam logic [1:0] DIV_C   = 2'd2;
  localparam logic [1:0] PUBLISH = 2'd3;

  localparam int               BW       = $clog2(SUM_W + 1);
  localparam logic [BW-1:0]    LAST_BIT = BW'(SUM_W - 1);
  localparam logic [SUM_W-1:0] SUM_MAX  = {SUM_W{1'b1}};
  localparam logic [SUM_W-1:0] MIN_CNT  = SUM_W'(MIN_PIXELS);

  logic [1:0]         state_q, state_d;
  logic [BW-1:0]      bit_q, bit_d;
  logic [SUM_W-1:0]   sum_r_q, sum_r_d, sum_c_q, sum_c_d, cnt_q, cnt_d;
  logic               sat_q, sat_d;
  logic [SUM_W-1:0]   dsum_c_q, dsum_c_d, dcnt_q, dcnt_d;
  logic               dsat_q, dsat_d;
  logic [SUM_W-1:0]   rem_q, rem_d, quo_q, quo_d;
  logic [COORD_W-1:0] qr_q, qr_d;
  logic               pub_vld_q, pub_vld_d, pub_found_q, pub_found_d;
  logic [COORD_W-1:0] pub_row_q, pub_row_d, pub_col_q, pub_col_d;
  logic [COORD_W-1:0] ball_row_q, ball_row_d, ball_col_q, ball_col_d;
  logic               found_q, found_d, cv_q, cv_d, busy_q, busy_d, overrun_q, overrun_d;

  logic               hit, acc_upd, ovf, acc_sat;
  logic [SUM_W:0]     add_r, add_c, add_n;
  logic [SUM_W-1:0]   acc_r, acc_c, acc_n;
  logic [SUM_W:0]     shifted;
  logic               ge;
  logic [SUM_W-1:0]   rem_sub, rem_next, quo_next;

  // Accumulator candidates including this cycle's hit; any overflow saturates and latches sat
  assign hit     = bus.pix_valid & bus.mask;
  assign acc_upd = hit & ~sat_q;
  assign add_r   = {1'b0, sum_r_q} + {{(SUM_W + 1 - COORD_W){1'b0}}, bus.row};
  assign add_c   = {1'b0, sum_c_q} + {{(SUM_W + 1 - COORD_W){1'b0}}, bus.col};
  assign add_n   = {1'b0, cnt_q} + {{SUM_W{1'b0}}, 1'b1};
  assign ovf     = add_r[SUM_W] | add_c[SUM_W] | add_n[SUM_W];
  assign acc_r   = !acc_upd ? sum_r_q : (add_r[SUM_W] ? SUM_MAX : add_r[SUM_W-1:0]);
  assign acc_c   = !acc_upd ? sum_c_q : (add_c[SUM_W] ? SUM_MAX : add_c[SUM_W-1:0]);
  assign acc_n   = !acc_upd ? cnt_q   : (add_n[SUM_W] ? SUM_MAX : add_n[SUM_W-1:0]);
  assign acc_sat = sat_q | (hit & ovf);

  // Restoring step: remainder < divisor, so the subtraction fits in SUM_W bits when ge is set
  assign shifted  = {rem_q, quo_q[SUM_W-1]};
  assign ge       = shifted >= {1'b0, dcnt_q};
  assign rem_sub  = shifted[SUM_W-1:0] - dcnt_q;
  assign rem_next = ge ? rem_sub : shifted[SUM_W-1:0];
  assign quo_next = {quo_q[SUM_W-2:0], ge};

`ifdef CENTROID_IIR_EN
  logic               hist_q, hist_d;
  logic [COORD_W:0]   avg_r, avg_c;
  assign avg_r = ({1'b0, ball_row_q} + {1'b0, pub_row_q}) >> 1;
  assign avg_c = ({1'b0, ball_col_q} + {1'b0, pub_col_q}) >> 1;
`endif

  always_comb begin
    state_d     = state_q;
    bit_d       = bit_q;
    sum_r_d     = acc_r;
    sum_c_d     = acc_c;
    cnt_d       = acc_n;
    sat_d       = acc_sat;
    dsum_c_d    = dsum_c_q;
    dcnt_d      = dcnt_q;
    dsat_d      = dsat_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    qr_d        = qr_q;
    pub_vld_d   = 1'b0;
    pub_found_d = pub_found_q;
    pub_row_d   = pub_row_q;
    pub_col_d   = pub_col_q;
    ball_row_d  = ball_row_q;
    ball_col_d  = ball_col_q;
    found_d     = found_q;
    cv_d        = 1'b0;
    busy_d      = busy_q;
    overrun_d   = overrun_q;
`ifdef CENTROID_IIR_EN
    hist_d      = hist_q;
`endif

    if (bus.frame_end) begin
      sum_r_d = '0;
      sum_c_d = '0;
      cnt_d   = '0;
      sat_d   = 1'b0;
      if (busy_q) begin
        overrun_d = 1'b1;
      end else begin
        quo_d    = acc_r;
        rem_d    = '0;
        dsum_c_d = acc_c;
        dcnt_d   = acc_n;
        dsat_d   = acc_sat;
        bit_d    = '0;
        state_d  = DIV_R;
        busy_d   = 1'b1;
      end
    end

    case (state_q)
      DIV_R, DIV_C: begin
        rem_d = rem_next;
        quo_d = quo_next;
        bit_d = bit_q + BW'(1);
        if (bit_q == LAST_BIT) begin
          bit_d = '0;
          if (state_q == DIV_R) begin
            qr_d    = quo_next[COORD_W-1:0];
            rem_d   = '0;
            quo_d   = dsum_c_q;
            state_d = DIV_C;
          end else begin
            state_d = PUBLISH;
          end
        end
      end
      PUBLISH: begin
        pub_vld_d   = 1'b1;
        pub_found_d = (dcnt_q >= MIN_CNT) && !dsat_q;
        pub_row_d   = qr_q;
        pub_col_d   = quo_q[COORD_W-1:0];
        state_d     = ACCUM;
      end
      default: ;
    endcase

    // Output stage: busy stays high until the cycle the new result is visible
    if (pub_vld_q) begin
      cv_d    = 1'b1;
      busy_d  = 1'b0;
      found_d = pub_found_q;
      if (pub_found_q) begin
`ifdef CENTROID_IIR_EN
        if (hist_q) begin
          ball_row_d = avg_r[COORD_W-1:0];
          ball_col_d = avg_c[COORD_W-1:0];
        end else begin
          ball_row_d = pub_row_q;
          ball_col_d = pub_col_q;
        end
        hist_d = 1'b1;
`else
        ball_row_d = pub_row_q;
        ball_col_d = pub_col_q;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ACCUM;
      bit_q       <= '0;
      sum_r_q     <= '0;
      sum_c_q     <= '0;
      cnt_q       <= '0;
      sat_q       <= 1'b0;
      dsum_c_q    <= '0;
      dcnt_q      <= '0;
      dsat_q      <= 1'b0;
      rem_q       <= '0;
      quo_q       <= '0;
      qr_q        <= '0;
      pub_vld_q   <= 1'b0;
      pub_found_q <= 1'b0;
      pub_row_q   <= '0;
      pub_col_q   <= '0;
      ball_row_q  <= '0;
      ball_col_q  <= '0;
      found_q     <= 1'b0;
      cv_q        <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef CENTROID_IIR_EN
      hist_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      bit_q       <= bit_d;
      sum_r_q     <= sum_r_d;
      sum_c_q     <= sum_c_d;
      cnt_q       <= cnt_d;
      sat_q       <= sat_d;
      dsum_c_q    <= dsum_c_d;
      dcnt_q      <= dcnt_d;
      dsat_q      <= dsat_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      qr_q        <= qr_d;
      pub_vld_q   <= pub_vld_d;
      pub_found_q <= pub_found_d;
      pub_row_q   <= pub_row_d;
      pub_col_q   <= pub_col_d;
      ball_row_q  <= ball_row_d;
      ball_col_q  <= ball_col_d;
      found_q     <= found_d;
      cv_q        <= cv_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
`ifdef CENTROID_IIR_EN
      hist_q      <= hist_d;
`endif
    end
  end

  assign bus.ball_row       = ball_row_q;
  assign bus.ball_col       = ball_col_q;
  assign bus.ball_found     = found_q;
  assign bus.centroid_valid = cv_q;
  assign bus.busy           = busy_q;
  assign bus.overrun        = overrun_q;
endmodule

// File: tb/tb_ball_centroid.sv
// Bench for ball_centroid: random and directed frames, expected centroids queued per frame_end
// from a hit-list reference model and checked by an independent monitor on centroid_valid.
`timescale 1ns/1ps
module tb_ball_centroid;
  localparam int COORD_W    = 13;
  localparam int SUM_W      = 32;
  localparam int MIN_PIXELS = 16;
  localparam int LAT        = 2 * SUM_W + 2;

  typedef struct {
    longint cyc;
    longint row;
    longint col;
    longint found;
  } exp_t;

  logic   clk = 1'b0;
  logic   reset_n = 1'b0;
  longint cyc = 0;
  int     checks = 0;
  int     errors = 0;

  exp_t   sb[$];
  int     hr[$];
  int     hc[$];
  longint busy_end = -1;
  longint ovr_exp = 0;
  longint last_row = 0;
  longint last_col = 0;
  bit     hist = 1'b0;
  exp_t   mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ball_centroid_if #(.COORD_W(COORD_W)) bus();

  ball_centroid #(
    .COORD_W(COORD_W),
    .SUM_W(SUM_W),
    .MIN_PIXELS(MIN_PIXELS)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  task automatic check(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: a frame's centroid is the integer mean of its hit coordinates
  function automatic void close_frame(longint k);
    longint sr, sc, nr, nc;
    int     n;
    exp_t   e;
    sr = 0;
    sc = 0;
    if (k <= busy_end) begin
      ovr_exp = 1;
    end else begin
      n = hr.size();
      foreach (hr[i]) begin
        sr += hr[i];
        sc += hc[i];
      end
      e.cyc   = k + LAT;
      e.found = (n >= MIN_PIXELS) ? 1 : 0;
      if (n >= MIN_PIXELS) begin
        nr = sr / n;
        nc = sc / n;
`ifdef CENTROID_IIR_EN
        if (hist) begin
          nr = (last_row + nr) / 2;
          nc = (last_col + nc) / 2;
        end
        hist = 1'b1;
`endif
        last_row = nr;
        last_col = nc;
      end
      e.row = last_row;
      e.col = last_col;
      sb.push_back(e);
      busy_end = k + LAT;
    end
    hr.delete();
    hc.delete();
  endfunction

  function automatic void model_reset();
    sb.delete();
    hr.delete();
    hc.delete();
    busy_end = -1;
    ovr_exp  = 0;
    last_row = 0;
    last_col = 0;
    hist     = 1'b0;
  endfunction

  // Called #1 after a rising edge; the values are sampled at the next edge
  task automatic issue(bit v, bit m, int r, int c, bit fe);
    longint k;
    k = cyc + 1;
    bus.pix_valid = v;
    bus.mask      = m;
    bus.row       = COORD_W'(r);
    bus.col       = COORD_W'(c);
    bus.frame_end = fe;
    if (v && m) begin
      hr.push_back(r);
      hc.push_back(c);
    end
    if (fe) close_frame(k);
    @(posedge clk);
    #1;
    bus.pix_valid = 1'b0;
    bus.mask      = 1'b0;
    bus.frame_end = 1'b0;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) issue(1'b0, 1'b0, 0, 0, 1'b0);
  endtask

  // 5x5 block of hits with frame_end on the last hit; centroid is (r0+2, c0+2)
  task automatic block(int r0, int c0);
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        issue(1'b1, 1'b1, r0 + r, c0 + c, (r == 4 && c == 4));
  endtask

  task automatic drain();
    int i;
    i = 0;
    while (sb.size() != 0 && i < 300) begin
      issue(1'b0, 1'b0, 0, 0, 1'b0);
      i++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d results still pending, expected 0", sb.size());
      sb.delete();
    end
  endtask

  always @(negedge clk) begin
    if (bus.centroid_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_cv: pulse at cycle %0d, expected none", cyc);
      end else begin
        mon_e = sb.pop_front();
        check("cv_cycle", cyc, mon_e.cyc);
        check("ball_row", longint'(bus.ball_row), mon_e.row);
        check("ball_col", longint'(bus.ball_col), mon_e.col);
        check("ball_found", longint'(bus.ball_found), mon_e.found);
        check("busy_at_cv", longint'(bus.busy), 0);
      end
    end else if (sb.size() != 0 && cyc >= sb[0].cyc) begin
      checks++;
      errors++;
      $display("FAIL missing_cv: no pulse at cycle %0d, expected one", cyc);
      sb.delete(0);
    end
  end

  task automatic check_all_zero(string tag);
    @(negedge clk);
    check({tag, "_row"}, longint'(bus.ball_row), 0);
    check({tag, "_col"}, longint'(bus.ball_col), 0);
    check({tag, "_found"}, longint'(bus.ball_found), 0);
    check({tag, "_cv"}, longint'(bus.centroid_valid), 0);
    check({tag, "_busy"}, longint'(bus.busy), 0);
    check({tag, "_overrun"}, longint'(bus.overrun), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int     r0, c0, len, pmask;
    longint k0;
    bus.pix_valid = 1'b0;
    bus.mask      = 1'b0;
    bus.row       = '0;
    bus.col       = '0;
    bus.frame_end = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    check_all_zero("reset");

    // 25-hit block centred on (102,202)
    block(100, 200);
    @(negedge clk);
    check("busy_after_fe", longint'(bus.busy), 1);
    @(posedge clk);
    #1;
    drain();

    // Too few hits: not found, position held
    for (int i = 0; i < 10; i++) issue(1'b1, 1'b1, 7, 9, (i == 9));
    drain();

    // Floor rounding with the frame_end-cycle hit counted: col = 168/16
    for (int i = 0; i < 16; i++) issue(1'b1, 1'b1, 5, (i < 8) ? 10 : 11, (i == 15));
    drain();

    // Reset 30 cycles into a division drops the result
    block(100, 200);
    k0 = cyc;
    while (cyc < k0 + 29) issue(1'b0, 1'b0, 0, 0, 1'b0);
    reset_n = 1'b0;
    model_reset();
    issue(1'b0, 1'b0, 0, 0, 1'b0);
    reset_n = 1'b1;
    check_all_zero("midreset");
    idle(70);
    block(100, 200);
    drain();

    // frame_end while busy: overrun, second frame dropped
    block(100, 200);
    for (int i = 0; i < 19; i++) issue(1'b1, 1'b1, 3000, 4000, (i == 18));
    @(negedge clk);
    check("overrun_set", longint'(bus.overrun), ovr_exp);
    @(posedge clk);
    #1;
    drain();

    // Random frames, some found and some not
    for (int f = 0; f < 12; f++) begin
      r0    = $urandom_range(0, 8000);
      c0    = $urandom_range(0, 8000);
      len   = $urandom_range(70, 140);
      pmask = $urandom_range(0, 1) ? 2 : 12;
      for (int i = 0; i < len; i++)
        issue($urandom_range(0, 3) != 0, $urandom_range(0, pmask - 1) == 0,
              r0 + $urandom_range(0, 15), c0 + $urandom_range(0, 15), (i == len - 1));
    end
    drain();

    // Two found frames back to back: (102,202) then (110,210)
    block(100, 200);
    drain();
    block(108, 208);
    drain();

    @(negedge clk);
    check("overrun_sticky", longint'(bus.overrun), ovr_exp);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ball_centroid.md
Name: ball_centroid

Overview:
- Upstream neighbour of the ball-overlay stage. Consumes the denoised HSV mask pixel stream and accumulates the row/column sums and pixel count of mask hits over a frame.
- At frame end it divides sums by count with a sequential restoring divider. It publishes ball_row/ball_col once per frame for the overlay and downstream logic.

Parameters:
- COORD_W, 13, width of row/col coordinates.
- SUM_W, 32, width of sum accumulators, count and divider datapath.
- MIN_PIXELS, 16, minimum mask hits for a frame to report a ball.

Ports:
- clk  input  1  pixel clock; single clock domain.
- reset_n  input  1  synchronous, active-low reset.
- pix_valid  input  1  qualifies row/col/mask this cycle.
- row  input  COORD_W  current pixel row.
- col  input  COORD_W  current pixel column.
- mask  input  1  denoised colour-match bit for the current pixel.
- frame_end  input  1  single-cycle pulse closing the current frame.
- ball_row  output  COORD_W  centroid row, held between updates.
- ball_col  output  COORD_W  centroid column, held between updates.
- ball_found  output  1  last completed frame had count >= MIN_PIXELS.
- centroid_valid  output  1  one-cycle pulse when outputs update.
- busy  output  1  divider active.
- overrun  output  1  sticky: a frame_end arrived while busy.

Behaviour:
- Reset (reset_n=0 at a clk edge): all outputs 0; accumulators, count, divider and FSM cleared; state ACCUM. Applies mid-division too: the in-flight result is discarded and no centroid_valid is issued.
- Accumulation: every cycle with pix_valid=1 and mask=1 adds row to sum_r and col to sum_c, and increments cnt. Widths are zero-extended to SUM_W.
- A hit on the same cycle as frame_end belongs to the closing frame.
- Saturation: if any accumulator would exceed 2^SUM_W-1, all three hold at their saturated values and the frame is forced not-found.
- frame_end with busy=0: snapshot sum_r, sum_c, cnt (including the same-cycle hit) into divider registers. Clear the accumulators the same edge. busy=1 next cycle.
- Accumulation of the next frame continues concurrently with the division.
- frame_end with busy=1: overrun set (sticky until reset). That frame's accumulators are cleared and its data dropped. The in-flight division completes normally.
- FSM states: ACCUM (idle) -> DIV_R (SUM_W cycles, one quotient bit/cycle, MSB first) -> DIV_C (SUM_W cycles) -> PUBLISH (1 cycle) -> ACCUM.
- Divisions always run, even when not found, so latency is fixed.
- Latency: centroid_valid is high exactly 2*SUM_W+2 cycles after the edge sampling frame_end (66 for defaults). busy falls the same cycle centroid_valid rises.
- Quotients are floor(sum/cnt), truncated to COORD_W. The result always fits because each sum/cnt <= the maximum coordinate.
- PUBLISH when found (cnt >= MIN_PIXELS, not saturated): ball_row/ball_col take the quotients and ball_found=1.
- PUBLISH when not found: ball_row/ball_col hold their previous values, ball_found=0, and centroid_valid still pulses.
- cnt=0 never reaches a divide result: not found by definition (MIN_PIXELS >= 1 required).

Optional Feature:
- Macro CENTROID_IIR_EN.
- Defined: on a found PUBLISH, with a previous found frame since reset, outputs become floor((old + new)/2), computed at COORD_W+1 bits. The first found frame after reset loads new directly. Not-found frames do not break the history.
- Undefined: outputs load new quotients directly. No extra registers are synthesised.

Test Plan:
- 5x5 mask block rows 100-104, cols 200-204 (25 hits), then frame_end -> 66 cycles later centroid_valid=1 for 1 cycle, ball_row=102, ball_col=202, ball_found=1, busy low the same cycle.
- Frame with 10 hits after the above -> centroid_valid pulses, ball_found=0, ball_row/ball_col remain 102/202.
- MIN_PIXELS=2, hits at (5,10) and (5,11), the (5,11) hit on the frame_end cycle -> ball_row=5, ball_col=10 (floor, same-cycle hit counted).
- Second frame_end 20 cycles after the first -> overrun=1 and stays 1; the first frame's result still published at 66 cycles; no second centroid_valid.
- reset_n=0 for 1 cycle at cycle 30 of a division -> all outputs 0, no centroid_valid; the next frame with 25 hits at (102,202) publishes correctly.
- CENTROID_IIR_EN defined: frame centroid (102,202) then frame centroid (110,210) -> second publish ball_row=106, ball_col=206.
